// File: rtl/combo_sequence_detector_if.sv
// ============================================================================
// Module      : combo_sequence_detector_if
// Description : Button-pulse input and combo-result output bundle for
//               combo_sequence_detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface combo_sequence_detector_if;
  logic [4:0] btn_pulse;
  logic       facing;
  logic       combo_valid;
  logic [1:0] combo_id;
  logic       window_open;
  logic [1:0] step_count;

  modport master (
    output btn_pulse,
    output facing,
    input  combo_valid,
    input  combo_id,
    input  window_open,
    input  step_count
  );

  modport slave (
    input  btn_pulse,
    input  facing,
    output combo_valid,
    output combo_id,
    output window_open,
    output step_count
  );
endinterface

`default_nettype wire

// File: rtl/combo_sequence_detector.sv
// ============================================================================
// Module      : combo_sequence_detector
// Description : Per-player combo window that matches a 3-press history
//               against fixed special-move sequences. Option macro
//               COMBO_MIRROR_EN swaps left/right when facing left.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module combo_sequence_detector #(
  parameter int TIMEOUT_CYCLES  = 25_000_000,
  parameter int COOLDOWN_CYCLES = 4_000_000,
  parameter int TIMER_W         = 32
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  combo_sequence_detector_if.slave bus
);

  localparam logic [2:0] c_code_none = 3'd0;
  localparam logic [2:0] c_code_up   = 3'd1;
  localparam logic [2:0] c_code_down = 3'd2;
  localparam logic [2:0] c_code_fwd  = 3'd3;
  localparam logic [2:0] c_code_back = 3'd4;
  localparam logic [2:0] c_code_atk  = 3'd5;

  // History packs oldest entry in the top bits, newest in [2:0]
  localparam logic [8:0] c_seq_hadouken = {c_code_down, c_code_fwd,  c_code_atk};
  localparam logic [8:0] c_seq_shoryu   = {c_code_fwd,  c_code_down, c_code_atk};
  localparam logic [8:0] c_seq_tatsu    = {c_code_down, c_code_back, c_code_atk};

  localparam logic [1:0] c_id_none     = 2'd0;
  localparam logic [1:0] c_id_hadouken = 2'd1;
  localparam logic [1:0] c_id_shoryu   = 2'd2;
  localparam logic [1:0] c_id_tatsu    = 2'd3;

  localparam logic [TIMER_W-1:0] c_timeout  = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] c_cooldown = TIMER_W'(COOLDOWN_CYCLES);
  localparam logic [TIMER_W-1:0] c_one      = TIMER_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TRACK    = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  state_t               r_state;
  logic [8:0]           r_hist;
  logic [1:0]           r_step;
  logic [TIMER_W-1:0]   r_timer;
  logic                 r_combo_valid;
  logic [1:0]           r_combo_id;
  logic                 r_window_open;

  logic                 w_fwd;
  logic                 w_back;
  logic [2:0]           w_code;
  logic                 w_press;
  logic [8:0]           w_hist_next;
  logic [1:0]           w_step_next;
  logic [1:0]           w_match_id;

`ifdef COMBO_MIRROR_EN
  // Facing is taken only on the press cycle; stored history is never rewritten
  assign w_fwd  = bus.facing ? bus.btn_pulse[2] : bus.btn_pulse[3];
  assign w_back = bus.facing ? bus.btn_pulse[3] : bus.btn_pulse[2];
`else
  logic w_unused_facing;
  assign w_unused_facing = bus.facing;
  assign w_fwd  = bus.btn_pulse[3];
  assign w_back = bus.btn_pulse[2];
`endif

  always_comb begin
    w_code = c_code_none;
    if (bus.btn_pulse[4])      w_code = c_code_atk;
    else if (bus.btn_pulse[1]) w_code = c_code_down;
    else if (bus.btn_pulse[0]) w_code = c_code_up;
    else if (w_fwd)            w_code = c_code_fwd;
    else if (w_back)           w_code = c_code_back;
  end

  assign w_press     = (w_code != c_code_none);
  assign w_hist_next = {r_hist[5:0], w_code};
  assign w_step_next = (r_step == 2'd3) ? 2'd3 : r_step + 2'd1;

  always_comb begin
    w_match_id = c_id_none;
    case (w_hist_next)
      c_seq_hadouken: w_match_id = c_id_hadouken;
      c_seq_shoryu:   w_match_id = c_id_shoryu;
      c_seq_tatsu:    w_match_id = c_id_tatsu;
      default:        w_match_id = c_id_none;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_hist        <= '0;
      r_step        <= 2'd0;
      r_timer       <= '0;
      r_combo_valid <= 1'b0;
      r_combo_id    <= c_id_none;
      r_window_open <= 1'b0;
    end else begin
      r_combo_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_TRACK: begin
          // A press on the last live cycle still extends the current window
          if (w_press) begin
            if (w_match_id != c_id_none) begin
              r_combo_valid <= 1'b1;
              r_combo_id    <= w_match_id;
              r_hist        <= '0;
              r_step        <= 2'd0;
              r_timer       <= c_cooldown;
              r_state       <= S_COOLDOWN;
              r_window_open <= 1'b0;
            end else begin
              r_hist        <= w_hist_next;
              r_step        <= w_step_next;
              r_timer       <= c_timeout;
              r_state       <= S_TRACK;
              r_window_open <= 1'b1;
            end
          end else if (r_state == S_TRACK) begin
            if (r_timer <= c_one) begin
              r_timer       <= '0;
              r_hist        <= '0;
              r_step        <= 2'd0;
              r_state       <= S_IDLE;
              r_window_open <= 1'b0;
            end else begin
              r_timer <= r_timer - c_one;
            end
          end
        end
        S_COOLDOWN: begin
          if (r_timer <= c_one) begin
            r_timer <= '0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer - c_one;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_hist        <= '0;
          r_step        <= 2'd0;
          r_timer       <= '0;
          r_window_open <= 1'b0;
        end
      endcase
    end
  end

  assign bus.combo_valid = r_combo_valid;
  assign bus.combo_id    = r_combo_id;
  assign bus.window_open = r_window_open;
  assign bus.step_count  = r_step;

endmodule

`default_nettype wire

// File: tb/tb_combo_sequence_detector.sv
// ============================================================================
// Module      : tb_combo_sequence_detector
// Description : Scoreboard bench for combo_sequence_detector (timeout 20,
//               cooldown 10); expectations follow COMBO_MIRROR_EN when set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_combo_sequence_detector;

  localparam int TO = 20;
  localparam int CD = 10;

  localparam logic [4:0] B_UP    = 5'b00001;
  localparam logic [4:0] B_DOWN  = 5'b00010;
  localparam logic [4:0] B_LEFT  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b01000;
  localparam logic [4:0] B_ATK   = 5'b10000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  combo_sequence_detector_if bus ();

  combo_sequence_detector #(
    .TIMEOUT_CYCLES (TO),
    .COOLDOWN_CYCLES(CD),
    .TIMER_W        (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] exp_q[$];
  logic       prev_valid = 1'b0;

  // Scoreboard consumer: every pulse must match the next queued move ID
  always @(negedge clk) begin
    if (bus.combo_valid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: combo_valid=1 combo_id=%0d, required no pulse", bus.combo_id);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (bus.combo_id !== e) begin
          n_fail++;
          $display("FAIL pulse_id: combo_id=%0d, required %0d", bus.combo_id, e);
        end
      end
      n_tests++;
      if (prev_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL pulse_width: combo_valid high two cycles in a row, required one");
      end
    end
    prev_valid = bus.combo_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] b, input logic f);
    bus.btn_pulse = b;
    bus.facing    = f;
    @(negedge clk);
    bus.btn_pulse = 5'b0;
  endtask

  task automatic drain(input string name);
    tick(3);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_pulse: %0d pulses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.btn_pulse = 5'b0;
    bus.facing    = 1'b0;
    #12;
    n_tests++;
    if ({bus.combo_valid, bus.combo_id, bus.window_open, bus.step_count} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: {valid,id,window,step}=%b, required 000000",
               {bus.combo_valid, bus.combo_id, bus.window_open, bus.step_count});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_hadouken;
    press(B_DOWN, 1'b0);
    n_tests++;
    if (bus.window_open !== 1'b1 || bus.step_count !== 2'd1) begin
      n_fail++;
      $display("FAIL had_first_press: window=%b step=%0d, required 1 and 1", bus.window_open, bus.step_count);
    end
    tick(4);
    press(B_RIGHT, 1'b0);
    n_tests++;
    if (bus.step_count !== 2'd2) begin
      n_fail++;
      $display("FAIL had_second_press: step=%0d, required 2", bus.step_count);
    end
    tick(4);
    exp_q.push_back(2'd1);
    press(B_ATK, 1'b0);
    n_tests++;
    if (bus.combo_valid !== 1'b1 || bus.combo_id !== 2'd1 ||
        bus.window_open !== 1'b0 || bus.step_count !== 2'd0) begin
      n_fail++;
      $display("FAIL had_fire: valid=%b id=%0d window=%b step=%0d, required 1 1 0 0",
               bus.combo_valid, bus.combo_id, bus.window_open, bus.step_count);
    end
    tick(1);
    n_tests++;
    if (bus.combo_valid !== 1'b0 || bus.combo_id !== 2'd1) begin
      n_fail++;
      $display("FAIL had_after: valid=%b id=%0d, required 0 and held 1", bus.combo_valid, bus.combo_id);
    end
    tick(CD + 2);
    drain("hadouken");
  endtask

  task automatic test_cooldown;
    press(B_RIGHT, 1'b0);
    tick(1);
    press(B_DOWN, 1'b0);
    tick(1);
    exp_q.push_back(2'd2);
    press(B_ATK, 1'b0);
    // Fire edge F leaves the timer at CD; these land on F+1..F+3
    press(B_DOWN, 1'b0);
    press(B_RIGHT, 1'b0);
    press(B_ATK, 1'b0);
    n_tests++;
    if (bus.step_count !== 2'd0 || bus.window_open !== 1'b0) begin
      n_fail++;
      $display("FAIL cd_ignored: step=%0d window=%b, required 0 and 0", bus.step_count, bus.window_open);
    end
    tick(CD - 4);
    press(B_DOWN, 1'b0);
    n_tests++;
    if (bus.step_count !== 2'd0 || bus.window_open !== 1'b0) begin
      n_fail++;
      $display("FAIL cd_last_cycle: step=%0d window=%b, required 0 and 0", bus.step_count, bus.window_open);
    end
    press(B_DOWN, 1'b0);
    n_tests++;
    if (bus.step_count !== 2'd1 || bus.window_open !== 1'b1) begin
      n_fail++;
      $display("FAIL cd_after: step=%0d window=%b, required 1 and 1", bus.step_count, bus.window_open);
    end
    tick(TO + 2);
    drain("cooldown");
  endtask

  task automatic test_timeout;
    press(B_DOWN, 1'b0);
    tick(TO - 1);
    n_tests++;
    if (bus.step_count !== 2'd1 || bus.window_open !== 1'b1) begin
      n_fail++;
      $display("FAIL to_before: step=%0d window=%b, required 1 and 1", bus.step_count, bus.window_open);
    end
    tick(1);
    n_tests++;
    if (bus.step_count !== 2'd0 || bus.window_open !== 1'b0) begin
      n_fail++;
      $display("FAIL to_expired: step=%0d window=%b, required 0 and 0", bus.step_count, bus.window_open);
    end
    tick(1);
    press(B_RIGHT, 1'b0);
    tick(2);
    press(B_ATK, 1'b0);
    n_tests++;
    if (bus.step_count !== 2'd2) begin
      n_fail++;
      $display("FAIL to_fresh_history: step=%0d, required 2", bus.step_count);
    end
    tick(TO + 2);
    drain("timeout");
  endtask

  task automatic test_timeout_edge;
    press(B_DOWN, 1'b0);
    tick(TO - 1);
    press(B_RIGHT, 1'b0);
    n_tests++;
    if (bus.step_count !== 2'd2 || bus.window_open !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_append: step=%0d window=%b, required 2 and 1", bus.step_count, bus.window_open);
    end
    exp_q.push_back(2'd1);
    press(B_ATK, 1'b0);
    tick(CD + 2);
    drain("timeout_edge");
  endtask

  task automatic test_priority_reset;
    press(B_DOWN | B_ATK, 1'b0);
    n_tests++;
    if (bus.step_count !== 2'd1) begin
      n_fail++;
      $display("FAIL prio_step: step=%0d, required 1", bus.step_count);
    end
    // ATK,FWD,ATK must not match; a DOWN-wins encoder would fire HADOUKEN
    press(B_RIGHT, 1'b0);
    press(B_ATK, 1'b0);
    n_tests++;
    if (bus.step_count !== 2'd3 || bus.window_open !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_history: step=%0d window=%b, required 3 and 1", bus.step_count, bus.window_open);
    end
    press(B_UP | B_RIGHT, 1'b0);
    press(B_DOWN, 1'b0);
    press(B_ATK, 1'b0);
    n_tests++;
    if (bus.step_count !== 2'd3) begin
      n_fail++;
      $display("FAIL prio_up_over_fwd: step=%0d, required 3 (no SHORYU)", bus.step_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.combo_valid, bus.combo_id, bus.window_open, bus.step_count} !== 6'b0) begin
      n_fail++;
      $display("FAIL async_reset: {valid,id,window,step}=%b, required 000000",
               {bus.combo_valid, bus.combo_id, bus.window_open, bus.step_count});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    n_tests++;
    if (bus.window_open !== 1'b0 || bus.step_count !== 2'd0) begin
      n_fail++;
      $display("FAIL post_reset: window=%b step=%0d, required 0 and 0", bus.window_open, bus.step_count);
    end
    drain("priority_reset");
  endtask

  task automatic test_mirror;
    logic [1:0] e_left;
    logic [1:0] e_right;
`ifdef COMBO_MIRROR_EN
    e_left  = 2'd1;
    e_right = 2'd3;
`else
    e_left  = 2'd3;
    e_right = 2'd1;
`endif
    press(B_DOWN, 1'b1);
    press(B_LEFT, 1'b1);
    exp_q.push_back(e_left);
    press(B_ATK, 1'b1);
    tick(CD + 2);
    press(B_DOWN, 1'b1);
    press(B_RIGHT, 1'b1);
    exp_q.push_back(e_right);
    press(B_ATK, 1'b1);
    tick(CD + 2);
    drain("mirror");
  endtask

  initial begin
    test_reset();
    test_hadouken();
    test_cooldown();
    test_timeout();
    test_timeout_edge();
    test_priority_reset();
    test_mirror();
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
